sb_config_loader: RTL

SB_CONFIG_LOADER -- requirements
Module: sb_config_loader

---
 rtl/sb_config_loader.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/sb_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : sb_config_loader
// Purpose  : Loads a wide switch-box configuration word from a narrow
//            valid/ready word stream. Words are collected in a shadow
//            register and copied to config_out in one step on commit, so
//            the fabric never sees a partially loaded configuration.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock        in   1             rising-edge clock
//   nreset       in   1             synchronous active-low reset
//   start        in   1             begin a new load (honoured in IDLE only)
//   abort        in   1             cancel the load (honoured in LOAD only)
//   data_in      in   WORD_WIDTH    configuration word
//   data_valid   in   1             data_in holds a valid word
//   data_ready   out  1             loader accepts a word this cycle
//   config_out   out  CONFIG_WIDTH  committed configuration
//   config_valid out  1             config_out holds a complete load
//   done         out  1             one-cycle pulse after commit
//   busy         out  1             state is not IDLE
//   word_count   out  clog2(N+1)    words accepted in the current load
// ============================================================================
module sb_config_loader #(
  parameter int CONFIG_WIDTH = 264,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                                          clock,
  input  logic                                          nreset,
  input  logic                                          start,
  input  logic                                          abort,
  input  logic [WORD_WIDTH-1:0]                         data_in,
  input  logic                                          data_valid,
  output logic                                          data_ready,
  output logic [CONFIG_WIDTH-1:0]                       config_out,
  output logic                                          config_valid,
  output logic                                          done,
  output logic                                          busy,
  output logic [$clog2(CONFIG_WIDTH/WORD_WIDTH+1)-1:0]  word_count
);

  // CONFIG_WIDTH must be an exact multiple of WORD_WIDTH; any remainder
  // bits would never be written by a word.
  localparam int C_NUM_WORDS = CONFIG_WIDTH / WORD_WIDTH;
  localparam int C_CNT_W     = $clog2(C_NUM_WORDS + 1);

  localparam logic [C_CNT_W-1:0] C_LAST_IDX = C_CNT_W'(C_NUM_WORDS - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;

  logic [CONFIG_WIDTH-1:0]   r_shadow;
  logic [CONFIG_WIDTH-1:0]   r_config;
  logic                      r_config_valid;
  logic                      r_done;
  logic [C_CNT_W-1:0]        r_word_count;

  logic                      w_in_idle;
  logic                      w_in_load;
  logic                      w_in_commit;
  logic                      w_accept;
  logic                      w_last_word;
  logic [C_NUM_WORDS-1:0]    w_word_we;

  // --------------------------------------------------------------------------
  // State decode and handshake
  // --------------------------------------------------------------------------
  assign w_in_idle   = (r_state == ST_IDLE);
  assign w_in_load   = (r_state == ST_LOAD);
  assign w_in_commit = (r_state == ST_COMMIT);

  // Abort wins over a simultaneous handshake: the word on that cycle is
  // dropped rather than written into the shadow register.
  assign w_accept    = w_in_load && data_valid && !abort;
  assign w_last_word = (r_word_count == C_LAST_IDX);

  // One write enable per word slot, selected by the running word count.
  genvar gi;
  generate
    for (gi = 0; gi < C_NUM_WORDS; gi++) begin : g_word_we
      assign w_word_we[gi] = w_accept && (r_word_count == C_CNT_W'(gi));
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        // abort has no meaning here, so start alone decides.
        if (start) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_accept && w_last_word) begin
          w_state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        // Single-cycle state; start and abort are not looked at.
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Word counter
  // --------------------------------------------------------------------------
  // Cleared when a load starts and on abort; otherwise it holds its final
  // value after a commit so the full count stays observable until the next
  // load begins. It can only reach C_NUM_WORDS, because the last accepted
  // word moves the FSM out of LOAD.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_word_count <= '0;
    end else if (w_in_idle && start) begin
      r_word_count <= '0;
    end else if (w_in_load && abort) begin
      r_word_count <= '0;
    end else if (w_accept) begin
      r_word_count <= r_word_count + C_CNT_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Shadow register
  // --------------------------------------------------------------------------
  // Word k lands at bits [k*WORD_WIDTH +: WORD_WIDTH]; word 0 is the LSBs.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_shadow <= '0;
    end else if (w_in_idle && start) begin
      r_shadow <= '0;
    end else begin
      for (int k = 0; k < C_NUM_WORDS; k++) begin
        if (w_word_we[k]) begin
          r_shadow[k*WORD_WIDTH +: WORD_WIDTH] <= data_in;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Committed configuration and done pulse
  // --------------------------------------------------------------------------
  // config_out is only ever written here, on the edge that ends COMMIT, so
  // the fabric sees the previous configuration throughout a load and the
  // new one appears in a single step.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_config       <= '0;
      r_config_valid <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_in_commit) begin
        r_config       <= r_shadow;
        r_config_valid <= 1'b1;
        r_done         <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign data_ready   = w_in_load;
  assign busy         = !w_in_idle;
  assign config_out   = r_config;
  assign config_valid = r_config_valid;
  assign done         = r_done;
  assign word_count   = r_word_count;

endmodule

`default_nettype wire
